// File: rtl/pipe_mem_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and the memory.
// master = pipeline memory stage, slave = memory.
interface pipe_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/pipe_mem_access.sv
// Memory stage of the 5-stage pipeline: EX/MEM register, req/ack data-memory
// access FSM with timeout, upstream stall generation and MEM/WB register.
// Optional macro MISALIGN_CHECK_EN: misaligned accesses are not issued and
// raise the sticky misalign_err output.
module pipe_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mem_stall,
  pipe_mem_access_if.master dmem,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
`ifdef MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        mem_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // EX/MEM register
  logic [31:0] r_malu;
  logic [31:0] r_mb;
  logic [4:0]  r_mrn;
  logic        r_mwreg;
  logic        r_mm2reg;
  logic        r_mwmem;

  // memory port and access bookkeeping
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mdata;
  logic          r_mem_err;

  // MEM/WB register
  logic [4:0]  r_wrn;
  logic        r_wwreg;
  logic        r_wm2reg;
  logic [31:0] r_walu;
  logic [31:0] r_wmo;

  logic w_mem_op;
  logic w_skip;
  logic w_stall;
  logic w_issue;
  logic w_timeout;

  assign w_mem_op = r_mm2reg | r_mwmem;

`ifdef MISALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_skip       = w_mem_op & (r_malu[1:0] != 2'b00);
  assign misalign_err = r_misalign_err;
`else
  assign w_skip = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state: ack beats timeout because it is tested first
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op) w_next = w_skip ? S_DONE : S_WAIT;
      S_WAIT: if (dmem.dmem_ack || (r_cnt == CNT_LAST)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM decoded controls: stall, issue and timeout strobes
  always_comb begin
    w_stall   = ((r_state == S_IDLE) && w_mem_op) || (r_state == S_WAIT);
    w_issue   = (r_state == S_IDLE) && w_mem_op && !w_skip;
    w_timeout = (r_state == S_WAIT) && !dmem.dmem_ack && (r_cnt == CNT_LAST);
  end

  // EX/MEM register: advance only when the stage is not stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_malu   <= '0;
      r_mb     <= '0;
      r_mrn    <= '0;
      r_mwreg  <= 1'b0;
      r_mm2reg <= 1'b0;
      r_mwmem  <= 1'b0;
    end else if (!w_stall) begin
      r_malu   <= ealu;
      r_mb     <= eb;
      r_mrn    <= ern;
      r_mwreg  <= ewreg;
      r_mm2reg <= em2reg;
      r_mwmem  <= ewmem;
    end
  end

  // memory request registers, wait counter, load data capture and error flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_mdata   <= '0;
      r_mem_err <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= r_mwmem;
            r_addr  <= r_malu;
            r_wdata <= r_mb;
            r_cnt   <= '0;
          end
`ifdef MISALIGN_CHECK_EN
          if (w_skip) begin
            r_mdata        <= '0;
            r_misalign_err <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_mdata <= r_mm2reg ? dmem.dmem_rdata : '0;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_mdata   <= '0;
            r_mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB register: a stalled cycle hands a bubble to writeback
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrn    <= '0;
      r_wwreg  <= 1'b0;
      r_wm2reg <= 1'b0;
      r_walu   <= '0;
      r_wmo    <= '0;
    end else if (!w_stall) begin
      r_wrn    <= r_mrn;
      r_wwreg  <= r_mwreg;
      r_wm2reg <= r_mm2reg;
      r_walu   <= r_malu;
      r_wmo    <= (r_state == S_DONE) ? r_mdata : '0;
    end else begin
      r_wwreg  <= 1'b0;
      r_wm2reg <= 1'b0;
    end
  end

  assign malu            = r_malu;
  assign mrn             = r_mrn;
  assign mwreg           = r_mwreg;
  assign mm2reg          = r_mm2reg;
  assign mem_stall       = w_stall;
  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign wrn             = r_wrn;
  assign wwreg           = r_wwreg;
  assign wm2reg          = r_wm2reg;
  assign walu            = r_walu;
  assign wmo             = r_wmo;
  assign mem_err         = r_mem_err;

endmodule

// File: doc/pipe_mem_access.md
Name: pipe_mem_access

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Contains the EX/MEM register and a req/ack data-memory access FSM for variable-latency memory.
- Produces mem_stall, which freezes PC, IF/ID and ID/EX.
- Contains the MEM/WB register that feeds the writeback stage.
- Exposes M-stage fields to the forwarding/hazard unit.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before abandoning the access (must be ≥1).

Ports:
- clock  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- ealu  in  32  execute result / effective address.
- eb  in  32  store data.
- ern  in  5  destination register.
- ewreg  in  1  register write enable.
- em2reg  in  1  load (result from memory).
- ewmem  in  1  store.
- malu  out  32  EX/MEM register: ALU result.
- mrn  out  5  EX/MEM register: destination register (to hazard unit).
- mwreg  out  1  EX/MEM register: write enable (to hazard unit).
- mm2reg  out  1  EX/MEM register: load flag (to hazard unit).
- mem_stall  out  1  freeze upstream stages; combinational from state and M-stage flags.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  32  registered, equals malu.
- dmem_wdata  out  32  registered, equals mb.
- dmem_rdata  in  32  read data, valid when dmem_ack = 1.
- dmem_ack  in  1  one-cycle completion pulse.
- wrn  out  5  MEM/WB register: destination register.
- wwreg  out  1  MEM/WB register: write enable.
- wm2reg  out  1  MEM/WB register: load flag.
- walu  out  32  MEM/WB register: ALU result.
- wmo  out  32  MEM/WB register: memory data.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, active-high) clears every register: all outputs 0 (including mb), state = IDLE, timeout counter = 0. A reset mid-access drops dmem_req immediately; the in-flight access is abandoned.
- mem_op = mm2reg | mwmem.
- EX/MEM register: loads malu, mb, mrn, mwreg, mm2reg, mwmem from the e* inputs on each rising edge where mem_stall = 0; holds otherwise.
- mem_stall = 1 when (state == IDLE and mem_op) or state == WAIT; 0 in DONE and for non-memory instructions.
- FSM states:
  - IDLE:
    - If mem_op: on the next edge go to WAIT; register dmem_req = 1, dmem_we = mwmem, dmem_addr = malu, dmem_wdata = mb; clear the counter.
    - Otherwise stay in IDLE.
  - WAIT:
    - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
    - Counter increments each cycle.
    - On an edge with dmem_ack = 1: capture mdata = dmem_rdata (loads only; stores capture 0), dmem_req <= 0, go to DONE.
    - Else if the counter has reached TIMEOUT_CYCLES - 1: dmem_req <= 0, mdata <= 0, mem_err <= 1, go to DONE.
    - If ack and timeout coincide, ack wins: mem_err is not set.
  - DONE: single cycle, mem_stall = 0, then go to IDLE unconditionally. A memory op loaded in this cycle is started from IDLE.
- dmem_ack outside WAIT is ignored.
- MEM/WB register, on every edge:
  - If mem_stall = 0: wrn = mrn, wwreg = mwreg, wm2reg = mm2reg, walu = malu, wmo = (state == DONE ? mdata : 0).
  - If mem_stall = 1: insert a bubble (wwreg = 0, wm2reg = 0, other fields hold). No instruction writes back twice.
- Latency:
  - Non-memory instruction: 1 cycle in M, no stall.
  - Memory instruction with zero-wait memory (ack in the first WAIT cycle): 3 cycles in M, 2 of them stalled (IDLE, WAIT, DONE).
  - Each extra wait cycle adds 1.
- mem_err: stays 1 until reset; the pipeline continues after a timeout.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: when a mem_op has malu[1:0] != 0, the access is not issued.
  - The FSM goes IDLE -> DONE directly; dmem_req stays 0.
  - mdata = 0 and the sticky output misalign_err (extra 1-bit output, reset 0) is set.
  - mem_stall for this instruction lasts 1 cycle.
- Undefined: no misalign_err port; address bits [1:0] are passed to memory unchanged.

Test Plan:
- Reset released, ALU-only op (ealu = 0x10, ern = 3, ewreg = 1), no stall -> 2 edges later wrn = 3, wwreg = 1, walu = 0x10; mem_stall never 1.
- Load with ealu = 0x40 and ack in the first WAIT cycle with dmem_rdata = 0xDEADBEEF -> dmem_req high exactly 1 cycle, dmem_addr = 0x40, dmem_we = 0; mem_stall high 2 cycles; then wm2reg = 1, wmo = 0xDEADBEEF, and wwreg = 1 exactly once.
- Store with ealu = 0x80, eb = 0x12345678, ack after 3 wait cycles -> dmem_we = 1, dmem_wdata = 0x12345678 held stable for 4 cycles; mem_stall high 5 cycles; EX/MEM holds the next instruction throughout.
- TIMEOUT_CYCLES = 4, load, never ack -> dmem_req drops after 4 WAIT cycles; mem_err = 1; wmo = 0; a subsequent ALU op still retires.
- Ack arriving on the same edge as the timeout -> mem_err stays 0 and wmo = rdata.
- reset asserted during WAIT -> dmem_req = 0 and all outputs = 0 immediately; a late ack after reset is released is ignored.
